// File: rtl/wave_buf_pkg.sv
// -----------------------------------------------------------------------------
// wave_buf_pkg
//   Shared display constants for the waveform trace path (trace geometry,
//   sample width, read latency) plus the pipeline stage record and the
//   circular-buffer address helper used by wave_buf.
//   The GUI stage imports the same constants so both sides agree on the
//   trace area and on the look-ahead distance of the pixel coordinates.
// -----------------------------------------------------------------------------
package wave_buf_pkg;

    // Trace geometry: buffer depth equals trace width, WAVE_H == 2**DW.
    localparam int WAVE_W  = 500;
    localparam int WAVE_H  = 256;
    localparam int DW      = 8;

    // Look-ahead distance between the pixel coordinates and wavepoint.
    localparam int RD_LAT  = 2;

    // Derived widths.
    localparam int COORD_W = 11;                     // pixel_xpos / pixel_ypos
    localparam int PTR_W   = $clog2(WAVE_W);         // RAM address
    localparam int CNT_W   = $clog2(WAVE_W + 1);     // fill count 0..WAVE_W
    localparam int SUM_W   = COORD_W + 1;            // base + x without overflow

    // Per-pixel flags carried from the address stage to the compare stage,
    // alongside the RAM read that is in flight.
    typedef struct packed {
        logic          in_area;    // x < WAVE_W && y < WAVE_H
        logic          col_valid;  // column holds a captured sample
        logic          first_col;  // x == 0: no left neighbour to join
        logic [DW-1:0] y;          // row, meaningful only when in_area
    } px_stage_t;

    // Map a screen column onto a buffer slot, starting at the oldest sample.
    // Columns past the trace can still land beyond the last slot after one
    // subtraction; they are parked on slot 0 since their pixels are blanked.
    function automatic logic [PTR_W-1:0] wrap_addr(
        input logic [PTR_W-1:0]   base,
        input logic [COORD_W-1:0] x
    );
        logic [SUM_W-1:0] a;
        a = SUM_W'(base) + SUM_W'(x);
        if (a >= SUM_W'(WAVE_W)) begin
            a = a - SUM_W'(WAVE_W);
        end
        if (a >= SUM_W'(WAVE_W)) begin
            a = '0;
        end
        return a[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/wave_ram.sv
// -----------------------------------------------------------------------------
// wave_ram
//   Simple dual-port sample store, DEPTH x WIDTH. One write port and one
//   registered read port on the same clock. A read and a write to the same
//   slot on one edge return the word that was stored before the write
//   (read-first), so the trace never shows a half-updated column.
//
// Ports
//   clk      in   1       clock
//   wr_en    in   1       write strobe
//   wr_addr  in   AW      write slot
//   wr_data  in   WIDTH   word to store
//   rd_addr  in   AW      read slot, sampled on the clock edge
//   rd_data  out  WIDTH   word at rd_addr, valid one clock later
// -----------------------------------------------------------------------------
module wave_ram
    import wave_buf_pkg::*;
#(
    parameter int DEPTH = WAVE_W,
    parameter int WIDTH = DW,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    // NOTE: the array and its read register carry no reset, so they map onto
    // block RAM; non-blocking updates make the same-edge read see the old
    // word, which is exactly the read-first behaviour.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/wave_buf.sv
// -----------------------------------------------------------------------------
// wave_buf
//   Scrolling waveform store and trace renderer for the LCD display path.
//   Incoming samples fill a circular buffer of WAVE_W columns. For every
//   pixel the GUI is about to paint, wavepoint says whether it lies on the
//   trace: columns run oldest-left/newest-right, sample value 0 sits on the
//   bottom row, and each column is drawn as a vertical segment joining its
//   sample to the one on its left so steep edges stay continuous.
//   The buffer view (start slot and number of valid columns) is frozen at
//   pixel (0,0) so a frame is always drawn from one consistent snapshot.
//
// Ports
//   lcd_pclk      in   1        pixel clock, sole clock
//   rst_n         in   1        asynchronous active-low reset
//   sample_valid  in   1        one-cycle strobe, sample_data valid
//   sample_data   in   DW       unsigned waveform sample
//   hold          in   1        1 = ignore sample_valid (freeze trace)
//   clr           in   1        synchronous buffer clear, wins over a write
//   pixel_xpos    in   11       look-ahead X, RD_LAT clocks ahead of the GUI
//   pixel_ypos    in   11       look-ahead Y, same timing
//   wavepoint     out  1        0 = pixel on trace, 1 = background
//   buf_full      out  1        WAVE_W samples captured since reset/clr
// -----------------------------------------------------------------------------
module wave_buf
    import wave_buf_pkg::*;
(
    input  logic               lcd_pclk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic [DW-1:0]      sample_data,
    input  logic               hold,
    input  logic               clr,
    input  logic [COORD_W-1:0] pixel_xpos,
    input  logic [COORD_W-1:0] pixel_ypos,
    output logic               wavepoint,
    output logic               buf_full
);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             buf_full_q, buf_full_d;
    logic [PTR_W-1:0] base_ptr_q, base_ptr_d;
    logic [CNT_W-1:0] fill_lat_q, fill_lat_d;
    px_stage_t        s1_q,       s1_d;
    logic [DW-1:0]    s_prev_q,   s_prev_d;
    logic             wavepoint_q, wavepoint_d;

    logic             wr_en;
    logic             frame_start;
    logic [PTR_W-1:0] rd_addr;
    logic [DW-1:0]    s_cur;

    // ---------------------------------------------------------------------
    // Write side: pointer and fill count
    // ---------------------------------------------------------------------
    assign wr_en = sample_valid & ~hold & ~clr;

    // NOTE: every output of a combinational block gets a default on entry so
    // no path through the if/else chain can leave it holding a value (latch).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        if (clr) begin
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
        end else if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(WAVE_W - 1)) ? '0
                                                        : wr_ptr_q + PTR_W'(1);
            if (fill_cnt_q != CNT_W'(WAVE_W)) begin
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
        end
        buf_full_d = (fill_cnt_d == CNT_W'(WAVE_W));
    end

    // ---------------------------------------------------------------------
    // Frame latch at pixel (0,0). Pre-write pointer and count are used, so
    // a sample arriving on the same clock shows up one frame later.
    // ---------------------------------------------------------------------
    assign frame_start = (pixel_xpos == '0) && (pixel_ypos == '0);

    always_comb begin
        base_ptr_d = base_ptr_q;
        fill_lat_d = fill_lat_q;
        if (frame_start) begin
            // While filling, the oldest sample is in slot 0; once full it is
            // the slot about to be overwritten next.
            base_ptr_d = buf_full_q ? wr_ptr_q : '0;
            fill_lat_d = fill_cnt_q;
        end
    end

    // ---------------------------------------------------------------------
    // S0: read address and pixel flags. The _d view is used so pixel (0,0)
    // is already drawn from the snapshot taken on its own clock.
    // ---------------------------------------------------------------------
    assign rd_addr = wrap_addr(base_ptr_d, pixel_xpos);

    always_comb begin
        s1_d.in_area   = (pixel_xpos < COORD_W'(WAVE_W)) &&
                         (pixel_ypos < COORD_W'(WAVE_H));
        s1_d.col_valid = (pixel_xpos < COORD_W'(fill_lat_d));
        s1_d.first_col = (pixel_xpos == '0);
        s1_d.y         = pixel_ypos[DW-1:0];
    end

    wave_ram #(
        .DEPTH (WAVE_W),
        .WIDTH (DW)
    ) u_wave_ram (
        .clk     (lcd_pclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (sample_data),
        .rd_addr (rd_addr),
        .rd_data (s_cur)
    );

    // ---------------------------------------------------------------------
    // S1/S2: s_cur is the registered RAM word for the delayed pixel; s_prev
    // is the column to its left, relying on x stepping by one per clock
    // within a line. At x==0 there is no left neighbour, so the column is
    // joined to itself and collapses to a single dot.
    // ---------------------------------------------------------------------
    always_comb begin
        logic [DW-1:0] prev_eff;
        logic [DW-1:0] row_c;
        logic [DW-1:0] row_p;
        logic [DW-1:0] row_lo;
        logic [DW-1:0] row_hi;
        logic          on_trace;

        prev_eff = s1_q.first_col ? s_cur : s_prev_q;
        row_c    = DW'(WAVE_H - 1) - s_cur;
        row_p    = DW'(WAVE_H - 1) - prev_eff;
        row_lo   = (row_c < row_p) ? row_c : row_p;
        row_hi   = (row_c < row_p) ? row_p : row_c;
        on_trace = s1_q.in_area & s1_q.col_valid &
                   (s1_q.y >= row_lo) & (s1_q.y <= row_hi);

        wavepoint_d = ~on_trace;
        s_prev_d    = s_cur;
    end

    // ---------------------------------------------------------------------
    // Registers. Reset blanks the trace at once and keeps it blank until the
    // next frame latch picks up the (now zero) fill count.
    // ---------------------------------------------------------------------
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            buf_full_q  <= 1'b0;
            base_ptr_q  <= '0;
            fill_lat_q  <= '0;
            s1_q        <= '0;
            s_prev_q    <= '0;
            wavepoint_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            buf_full_q  <= buf_full_d;
            base_ptr_q  <= base_ptr_d;
            fill_lat_q  <= fill_lat_d;
            s1_q        <= s1_d;
            s_prev_q    <= s_prev_d;
            wavepoint_q <= wavepoint_d;
        end
    end

    assign wavepoint = wavepoint_q;
    assign buf_full  = buf_full_q;

endmodule

// File: tb/tb_wave_buf.sv
// -----------------------------------------------------------------------------
// tb_wave_buf
//   Directed and randomized bench for wave_buf. A behavioural model keeps the
//   list of samples captured since reset/clr, takes a snapshot of the visible
//   columns whenever pixel (0,0) is presented, and derives each pixel from the
//   drawing rule (segment between this column's row and its left neighbour's).
// -----------------------------------------------------------------------------
module tb_wave_buf;
    import wave_buf_pkg::*;

    localparam int X_SCAN = WAVE_W + 4;   // include a few columns past the trace
    localparam int IDLE_C = 1023;         // off-screen coordinate between rows

    logic               lcd_pclk     = 1'b0;
    logic               rst_n        = 1'b0;
    logic               sample_valid = 1'b0;
    logic [DW-1:0]      sample_data  = '0;
    logic               hold         = 1'b0;
    logic               clr          = 1'b0;
    logic [COORD_W-1:0] pixel_xpos   = COORD_W'(IDLE_C);
    logic [COORD_W-1:0] pixel_ypos   = COORD_W'(IDLE_C);
    logic               wavepoint;
    logic               buf_full;

    wave_buf dut (
        .lcd_pclk     (lcd_pclk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .hold         (hold),
        .clr          (clr),
        .pixel_xpos   (pixel_xpos),
        .pixel_ypos   (pixel_ypos),
        .wavepoint    (wavepoint),
        .buf_full     (buf_full)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    int hist[$];            // samples captured since reset/clr, oldest first
    int snap_val[WAVE_W];   // column values visible in the current frame
    int snap_fill;          // number of drawn columns in the current frame
    int row_list[$];

    typedef struct {
        bit exp;
        int x;
        int y;
    } pend_t;
    pend_t pend_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void take_snapshot();
        int n;
        n = hist.size();
        snap_fill = (n > WAVE_W) ? WAVE_W : n;
        for (int c = 0; c < snap_fill; c++) begin
            // Once more than WAVE_W samples exist, only the newest WAVE_W show.
            snap_val[c] = (n >= WAVE_W) ? hist[n - WAVE_W + c] : hist[c];
        end
    endfunction

    function automatic bit model_pix(input int x, input int y);
        int cur, prev, rc, rp, lo, hi;
        if (x >= WAVE_W || y >= WAVE_H || x >= snap_fill) return 1'b1;
        cur  = snap_val[x];
        prev = (x == 0) ? cur : snap_val[x - 1];
        rc   = (WAVE_H - 1) - cur;
        rp   = (WAVE_H - 1) - prev;
        lo   = (rc < rp) ? rc : rp;
        hi   = (rc < rp) ? rp : rc;
        return !(y >= lo && y <= hi);
    endfunction

    // ---------------------------------------------------------------------
    // Checking and stimulus helpers
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic obs, input logic exp,
                         input int x, input int y);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s x=%0d y=%0d observed=%b expected=%b",
                   tag, x, y, obs, exp);
        end
    endtask

    // One pixel clock: drive coordinates (and optionally a sample), advance
    // the model, then compare the outputs that are due after the edge.
    task automatic tick(input int x, input int y, input bit wr,
                        input logic [DW-1:0] d);
        pend_t p;
        pixel_xpos = COORD_W'(x);
        pixel_ypos = COORD_W'(y);
        if (x == 0 && y == 0) take_snapshot();
        p.exp = model_pix(x, y);
        p.x   = x;
        p.y   = y;
        pend_q.push_back(p);
        sample_valid = wr;
        sample_data  = d;
        if (clr)              hist.delete();
        else if (wr && !hold) hist.push_back(int'(d));
        @(posedge lcd_pclk);
        #1;
        sample_valid = 1'b0;
        check("buf_full", buf_full, hist.size() >= WAVE_W, x, y);
        if (pend_q.size() >= RD_LAT) begin
            p = pend_q.pop_front();
            check("wavepoint", wavepoint, p.exp, p.x, p.y);
        end
    endtask

    task automatic write_sample(input logic [DW-1:0] d);
        tick(IDLE_C, IDLE_C, 1'b1, d);
    endtask

    task automatic clear_buf(input bit with_write);
        clr = 1'b1;
        tick(IDLE_C, IDLE_C, with_write, 8'h5A);
        clr = 1'b0;
    endtask

    task automatic scan_row(input int y, input int wr_x, input logic [DW-1:0] d);
        for (int x = 0; x < X_SCAN; x++) begin
            tick(x, y, x == wr_x, d);
        end
    endtask

    // Row 0 first (it carries the frame latch), then the rows in row_list.
    task automatic scan_frame();
        scan_row(0, -1, '0);
        foreach (row_list[i]) scan_row(row_list[i], -1, '0);
        repeat (RD_LAT) tick(IDLE_C, IDLE_C, 1'b0, '0);
    endtask

    task automatic model_reset();
        hist.delete();
        snap_fill = 0;
        pend_q.delete();
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        model_reset();
        repeat (3) @(posedge lcd_pclk);
        #3 rst_n = 1'b1;
        @(posedge lcd_pclk);
        #1;

        // 1) No samples: whole trace area blank, buffer empty.
        repeat (4) tick(IDLE_C, IDLE_C, 1'b0, '0);
        row_list = {1, 127, 128, 255, 256};
        scan_frame();

        // 2) Ten mid-scale samples: a flat line on row 127, columns 0..9.
        for (int i = 0; i < 10; i++) write_sample(8'h80);
        row_list = {126, 127, 128, 255};
        scan_frame();

        // 3) 0x00 then 0xFF: column 0 a dot at the bottom, column 1 a full
        //    vertical segment.
        clear_buf(1'b0);
        write_sample(8'h00);
        write_sample(8'hFF);
        row_list = {1, 128, 254, 255};
        scan_frame();

        // 4) 503 ramp samples: buffer fills, wraps, oldest three scroll out.
        clear_buf(1'b0);
        for (int k = 0; k < 503; k++) write_sample(8'(k & 8'hFF));
        row_list = {9, 100, 252, 255};
        scan_frame();

        // 5) hold freezes capture; clr beats a coincident write.
        hold = 1'b1;
        for (int i = 0; i < 20; i++) write_sample(8'(i * 7));
        hold = 1'b0;
        row_list = {9, 100, 252, 255};
        scan_frame();
        clear_buf(1'b1);
        row_list = {9, 255};
        scan_frame();

        // 6) A sample written mid-frame only appears after the next latch.
        for (int i = 0; i < 5; i++) write_sample(8'(40 + 30 * i));
        scan_row(0, -1, '0);
        scan_row(50, -1, '0);
        scan_row(100, 200, 8'h10);
        row_list = {};
        scan_row(239, -1, '0);
        scan_row(245, -1, '0);
        row_list = {245, 239, 215, 150};
        scan_frame();

        // Randomized content, filling and wrapping the buffer.
        clear_buf(1'b0);
        for (int i = 0; i < 700; i++) write_sample(8'($urandom_range(0, 255)));
        row_list = {int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), 255};
        scan_frame();
        for (int i = 0; i < 37; i++) write_sample(8'($urandom_range(0, 255)));
        row_list = {int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), 0};
        scan_frame();

        // Reset in the middle of a lit line: output blanks immediately and
        // stays blank through the following frame.
        clear_buf(1'b0);
        for (int i = 0; i < 100; i++) write_sample(8'h80);
        scan_row(0, -1, '0);
        for (int x = 0; x < 100; x++) tick(x, 127, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("reset_wavepoint", wavepoint, 1'b1, 99, 127);
        check("reset_buf_full", buf_full, 1'b0, 99, 127);
        model_reset();
        @(posedge lcd_pclk);
        #3 rst_n = 1'b1;
        for (int x = 100; x < X_SCAN; x++) tick(x, 127, 1'b0, '0);
        row_list = {127};
        scan_frame();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
